// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU request issuer.
// Build option: FPU_EXC_FLAG_EN adds a per-result Inf/NaN flag.
package fpu_pkg;

  localparam int FP_W    = 32;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;

  typedef enum logic [1:0] {
    FPU_ADD = 2'b00,
    FPU_SUB = 2'b01,
    FPU_MUL = 2'b10,
    FPU_DIV = 2'b11
  } fpu_op_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } issuer_state_e;

  // An all-ones exponent marks an Inf or NaN result.
  function automatic logic is_exc(input logic [FP_W-1:0] v);
    return &v[EXP_MSB:EXP_LSB];
  endfunction

endpackage

// File: rtl/fpu_res_fifo.sv
// Synchronous first-word-fall-through result FIFO with occupancy count.
// Pointers carry an extra MSB so full and empty are distinguishable.
module fpu_res_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; the read side is qualified by empty.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head_data = mem[rd_ptr[AW-1:0]];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count     = wr_ptr - rd_ptr;

endmodule

// File: rtl/fpu_req_issuer.sv
// Issues FP requests into a fixed-latency FPU, tracks tags, and buffers results.
// Build option: FPU_EXC_FLAG_EN adds output rsp_exc (Inf/NaN result flag).
module fpu_req_issuer
  import fpu_pkg::*;
#(
  parameter int FPU_LAT   = 3,
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [FP_W-1:0]  req_a,
  input  logic [FP_W-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [1:0]       fpu_operation,
  output logic [FP_W-1:0]  fpu_a_fpn,
  output logic [FP_W-1:0]  fpu_b_fpn,
  input  logic [FP_W-1:0]  fpu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [FP_W-1:0]  rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             flush,
  output logic             busy,
`ifdef FPU_EXC_FLAG_EN
  output logic             rsp_exc,
`endif
  output logic [1:0]       dbg_state
);

  localparam int AW    = $clog2(RES_DEPTH);
  localparam int CNT_W = AW + 1;
`ifdef FPU_EXC_FLAG_EN
  localparam int ENT_W = FP_W + TAG_W + 1;
`else
  localparam int ENT_W = FP_W + TAG_W;
`endif

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and payload is held while valid && !ready.

  issuer_state_e state, state_nxt;
  logic accept_en, fifo_clear, rsp_en;

  logic [FPU_LAT:0] pipe_vld;
  logic [TAG_W-1:0] pipe_tag [FPU_LAT+1];
  logic [CNT_W-1:0] inflight_cnt;
  logic [CNT_W:0]   credit_used;
  logic             issue, retire;

  logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [ENT_W-1:0] fifo_din, fifo_head;
  logic [AW:0]      fifo_cnt;

  assign credit_used = (CNT_W+1)'(inflight_cnt) + (CNT_W+1)'(fifo_cnt);
  assign req_ready   = rst && accept_en && (credit_used < (CNT_W+1)'(RES_DEPTH));
  assign issue       = req_valid && req_ready;
  assign retire      = pipe_vld[FPU_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpu_operation <= '0;
      fpu_a_fpn     <= '0;
      fpu_b_fpn     <= '0;
    end else if (issue) begin
      fpu_operation <= req_op;
      fpu_a_fpn     <= req_a;
      fpu_b_fpn     <= req_b;
    end
  end

  // The last tag stage lines up with the cycle the FPU presents that op's result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld <= '0;
      for (int i = 0; i <= FPU_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_vld    <= {pipe_vld[FPU_LAT-1:0], issue};
      pipe_tag[0] <= req_tag;
      for (int i = 1; i <= FPU_LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      inflight_cnt <= '0;
    else if (issue && !retire)
      inflight_cnt <= inflight_cnt + CNT_W'(1);
    else if (!issue && retire)
      inflight_cnt <= inflight_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (flush) state_nxt = ST_DRAIN;
      ST_DRAIN: if (inflight_cnt == '0) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    accept_en  = 1'b0;
    fifo_clear = 1'b0;
    rsp_en     = 1'b1;
    case (state)
      ST_RUN:   accept_en = 1'b1;
      ST_CLEAR: begin
        fifo_clear = 1'b1;
        rsp_en     = 1'b0;
      end
      default: ;
    endcase
  end

`ifdef FPU_EXC_FLAG_EN
  assign fifo_din = {is_exc(fpu_out), pipe_tag[FPU_LAT], fpu_out};
`else
  assign fifo_din = {pipe_tag[FPU_LAT], fpu_out};
`endif
  assign fifo_push = retire;
  assign fifo_pop  = rsp_valid && rsp_ready;

  fpu_res_fifo #(.W(ENT_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_cnt)
  );

  // Credit accounting must make this unreachable.
  assert property (@(posedge clk) disable iff (!rst) !(fifo_push && fifo_full && !fifo_pop));

  assign rsp_valid = rsp_en && !fifo_empty;
  assign rsp_data  = rsp_valid ? fifo_head[FP_W-1:0] : '0;
  assign rsp_tag   = rsp_valid ? fifo_head[FP_W +: TAG_W] : '0;
`ifdef FPU_EXC_FLAG_EN
  assign rsp_exc   = rsp_valid && fifo_head[FP_W+TAG_W];
`endif
  assign busy      = (inflight_cnt != '0) || !fifo_empty || (state != ST_RUN);
  assign dbg_state = state;

endmodule

// File: tb/tb_fpu_req_issuer.sv
// Directed bench for fpu_req_issuer with a fixed-latency FPU model.
// Build option: FPU_EXC_FLAG_EN enables the Inf/NaN flag checks.
module tb_fpu_req_issuer;
  import fpu_pkg::*;

  localparam int FPU_LAT   = 3;
  localparam int RES_DEPTH = 4;
  localparam int TAG_W     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       fpu_operation;
  logic [31:0]      fpu_a_fpn, fpu_b_fpn, fpu_out;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             flush, busy;
  logic [1:0]       dbg_state;
`ifdef FPU_EXC_FLAG_EN
  logic             rsp_exc;
`endif

  int n_checks = 0;
  int n_err    = 0;
  logic [FP_W+TAG_W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  fpu_req_issuer #(.FPU_LAT(FPU_LAT), .RES_DEPTH(RES_DEPTH), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_tag       (req_tag),
    .fpu_operation (fpu_operation),
    .fpu_a_fpn     (fpu_a_fpn),
    .fpu_b_fpn     (fpu_b_fpn),
    .fpu_out       (fpu_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_tag       (rsp_tag),
    .flush         (flush),
    .busy          (busy),
`ifdef FPU_EXC_FLAG_EN
    .rsp_exc       (rsp_exc),
`endif
    .dbg_state     (dbg_state)
  );

  // FPU golden model: hand-computed results for the vectors used below
  function automatic logic [31:0] golden(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case ({op, a, b})
      {2'b00, 32'h3F800000, 32'h40000000}: return 32'h40400000;
      {2'b00, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {2'b00, 32'h40000000, 32'h40000000}: return 32'h40800000;
      {2'b00, 32'h40400000, 32'h3F800000}: return 32'h40800000;
      {2'b01, 32'h40400000, 32'h3F800000}: return 32'h40000000;
      {2'b10, 32'h40000000, 32'h40400000}: return 32'h40C00000;
      {2'b10, 32'h40000000, 32'h40000000}: return 32'h40800000;
      {2'b11, 32'h3F800000, 32'h00000000}: return 32'h7F800000;
      default:                             return 32'hDEADBEEF;
    endcase
  endfunction

  logic [31:0] m_pipe [FPU_LAT] = '{default: '0};
  always @(posedge clk) begin
    m_pipe[0] <= golden(fpu_operation, fpu_a_fpn, fpu_b_fpn);
    for (int i = 1; i < FPU_LAT; i++) m_pipe[i] <= m_pipe[i-1];
  end
  assign fpu_out = m_pipe[FPU_LAT-1];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // driver: present one request and hold it until accepted (bounded)
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    int waited = 0;
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    #1;
    while (!req_ready && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("send_ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input logic [31:0] data, input logic [TAG_W-1:0] tag);
    int w = 0;
    while (!rsp_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_valid"}, 64'(rsp_valid), 64'(1));
    chk({name, "_data"}, 64'(rsp_data), 64'(data));
    chk({name, "_tag"}, 64'(rsp_tag), 64'(tag));
  endtask

  task automatic pop_one();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [31:0]      st_a [4] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40400000};
  logic [31:0]      st_b [4] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000};
  logic [31:0]      st_r [4] = '{32'h40000000, 32'h40800000, 32'h40400000, 32'h40800000};
  logic [TAG_W-1:0] st_t [4] = '{4'hA, 4'hB, 4'hC, 4'hD};

  initial begin
    int lat, acc, got, k, rdy_seen, stale, idx;
    logic [FP_W+TAG_W-1:0] e;

    rst = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    rsp_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_fpu_a", 64'(fpu_a_fpn), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("run_req_ready", 64'(req_ready), 64'(1));

    // single add, latency from accept to rsp_valid
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'h3F800000; req_b = 32'h40000000; req_tag = 4'd5;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    chk("add_fpu_op", 64'(fpu_operation), 64'(0));
    chk("add_fpu_a", 64'(fpu_a_fpn), 64'(32'h3F800000));
    chk("add_fpu_b", 64'(fpu_b_fpn), 64'(32'h40000000));
    chk("add_busy", 64'(busy), 64'(1));
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("add_latency", 64'(lat), 64'(FPU_LAT + 2));
    chk("add_data", 64'(rsp_data), 64'(32'h40400000));
    chk("add_tag", 64'(rsp_tag), 64'(5));
    pop_one();
    chk("add_popped", 64'(rsp_valid), 64'(0));
    chk("add_idle", 64'(busy), 64'(0));

    // back-to-back mul then sub, one result per cycle
    rsp_ready = 1'b1;
    send(2'b10, 32'h40000000, 32'h40400000, 4'd1);
    send(2'b01, 32'h40400000, 32'h3F800000, 4'd2);
    wait_rsp("b2b_mul", 32'h40C00000, 4'd1);
    @(negedge clk);
    chk("b2b_sub_valid", 64'(rsp_valid), 64'(1));
    chk("b2b_sub_data", 64'(rsp_data), 64'(32'h40000000));
    chk("b2b_sub_tag", 64'(rsp_tag), 64'(2));
    @(negedge clk);
    chk("b2b_empty", 64'(rsp_valid), 64'(0));
    rsp_ready = 1'b0;

    // credit limit: consumer stalled, offer a request every cycle
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      idx = acc % 4;
      req_valid = 1'b1; req_op = 2'b00; req_a = st_a[idx]; req_b = st_b[idx]; req_tag = st_t[idx];
      #1;
      if (req_ready) begin
        if (acc < 4) exp_q.push_back({st_t[idx], st_r[idx]});
        acc++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("credit_accepts", 64'(acc), 64'(RES_DEPTH));
    chk("credit_ready_low", 64'(req_ready), 64'(0));
    chk("credit_rsp_valid", 64'(rsp_valid), 64'(1));
    rsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("stream_extra", 64'(rsp_valid), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("stream_data", 64'(rsp_data), 64'(e[FP_W-1:0]));
          chk("stream_tag", 64'(rsp_tag), 64'(e[FP_W +: TAG_W]));
        end
        got++;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("stream_count", 64'(got), 64'(RES_DEPTH));
    chk("stream_q_empty", 64'(exp_q.size()), 64'(0));
    chk("stream_ready_back", 64'(req_ready), 64'(1));

    // flush with three in flight
    req_op = 2'b00; req_valid = 1'b1;
    req_a = 32'h3F800000; req_b = 32'h3F800000; req_tag = 4'd7; @(negedge clk);
    req_a = 32'h40000000; req_b = 32'h40000000; req_tag = 4'd8; @(negedge clk);
    req_a = 32'h3F800000; req_b = 32'h40000000; req_tag = 4'd9; @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    rdy_seen = 0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) flush = 1'b0;
      if (k == 2) flush = 1'b1;
      if (k == 3) begin
        flush = 1'b0;
        chk("drain_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("drain_rsp_tag", 64'(rsp_tag), 64'(7));
      end
      if (k == 5) begin
        chk("clear_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("clear_busy", 64'(busy), 64'(1));
      end
      if (!busy) break;
      if (req_ready) rdy_seen++;
    end
    chk("flush_busy_fall", 64'(k), 64'(6));
    chk("flush_no_ready", 64'(rdy_seen), 64'(0));
    chk("flush_rsp_gone", 64'(rsp_valid), 64'(0));
    chk("flush_ready_back", 64'(req_ready), 64'(1));
    send(2'b00, 32'h3F800000, 32'h40000000, 4'd3);
    wait_rsp("post_flush", 32'h40400000, 4'd3);
    pop_one();

    // asynchronous reset with two in flight
    send(2'b10, 32'h40000000, 32'h40000000, 4'd6);
    send(2'b10, 32'h40000000, 32'h40400000, 4'd4);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req_ready", 64'(req_ready), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_fpu_op", 64'(fpu_operation), 64'(0));
    chk("mid_rst_fpu_a", 64'(fpu_a_fpn), 64'(0));
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    chk("mid_rst_no_stale", 64'(stale), 64'(0));
    chk("mid_rst_idle", 64'(busy), 64'(0));

`ifdef FPU_EXC_FLAG_EN
    send(2'b11, 32'h3F800000, 32'h00000000, 4'd1);
    wait_rsp("div_zero", 32'h7F800000, 4'd1);
    chk("div_zero_exc", 64'(rsp_exc), 64'(1));
    pop_one();
    send(2'b00, 32'h3F800000, 32'h40000000, 4'd2);
    wait_rsp("add_noexc", 32'h40400000, 4'd2);
    chk("add_noexc_exc", 64'(rsp_exc), 64'(0));
    pop_one();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
